if_fetch: RTL and testbench

Instruction-fetch stage. It owns the architectural PC and drives if_pc/if_inst into the IF/ID pipeline register. It looks up a small direct-mapped instruction cache and, on a miss, issues a word request to the memory controller and stalls. It honours the EX branch-redirect and the stall vector with the same conventions as the IF/ID register.

---
 rtl/if_fetch_pkg.sv | 19 +
 rtl/if_fetch_if.sv | 15 +
 rtl/if_fetch_icache.sv | 45 ++++
 rtl/if_fetch.sv | 99 +++++++++
 tb/tb_if_fetch.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its cache.
package if_fetch_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int ICACHE_IDX_W_DEF = 7;
  localparam int STALL_W          = 6;
  localparam int INST_W           = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [0:0] {
    IF_IDLE = 1'b0,
    IF_WAIT = 1'b1
  } if_state_t;

  function automatic int icache_lines(input int idx_w);
    return 1 << idx_w;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-to-memory-controller word request channel.
// Handshake: master raises mem_req with a stable mem_addr and holds both until
// the slave pulses mem_ack for one cycle with mem_data valid; that cycle ends
// the request. The slave starts a transaction only while idle and mem_req is high.
interface if_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache: async read, sync write,
// valid bits cleared synchronously on reset (tags and data are not reset).
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W_DEF,
  parameter int TAG_W = ADDR_W_DEF - ICACHE_IDX_W_DEF - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit,
  output logic [INST_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [INST_W-1:0] wr_data
);

  localparam int LINES = icache_lines(IDX_W);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, looks up the icache, and on a miss
// fetches one word from the memory controller while stalling the pipeline.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [STALL_W-1:0] stall_stat,
  input  logic               ex_is_branch,
  input  logic [ADDR_W-1:0]  ex_branch_pc,
  input  logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INST_W-1:0]  if_inst,
  output logic               if_stall_req,
  if_fetch_if.master         mem,
  output if_state_t          fetch_state
);

  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

  logic [ADDR_W-1:0]       pc;
  logic [ADDR_W-3:0]       req_addr;
  if_state_t               state;
  logic                    redirect;
  logic                    hit;
  logic                    line_hit;
  logic                    fill;
  logic [INST_W-1:0]       line_data;
  logic                    unused_stall;

  assign unused_stall = ^stall_stat[STALL_W-1:1];

  // A branch that lands on the PC already in IF/ID is not a redirect.
  assign redirect = ex_is_branch && (ex_branch_pc != id_pc);
  assign hit      = line_hit && (state == IF_IDLE);
  assign fill     = rdy && (state == IF_WAIT) && mem.mem_ack;

  if_fetch_icache #(
    .IDX_W (ICACHE_IDX_W),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc[ICACHE_IDX_W+1:2]),
    .rd_tag  (pc[ADDR_W-1:ICACHE_IDX_W+2]),
    .rd_hit  (line_hit),
    .rd_data (line_data),
    .we      (fill),
    .wr_idx  (req_addr[ICACHE_IDX_W-1:0]),
    .wr_tag  (req_addr[ADDR_W-3:ICACHE_IDX_W]),
    .wr_data (mem.mem_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      state        <= IF_IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      req_addr     <= '0;
    end else begin
      if (redirect) begin
        pc <= ex_branch_pc;
      end else if (rdy && hit && !stall_stat[0]) begin
        pc <= pc + ADDR_W'(4);
      end
      // A redirect during WAIT does not abort the fill; it still targets req_addr.
      if (rdy) begin
        case (state)
          IF_IDLE: begin
            if (!hit && !redirect) begin
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= {pc[ADDR_W-1:2], 2'b00};
              req_addr     <= pc[ADDR_W-1:2];
              state        <= IF_WAIT;
            end
          end
          IF_WAIT: begin
            if (mem.mem_ack) begin
              mem.mem_req <= 1'b0;
              state       <= IF_IDLE;
            end
          end
          default: state <= IF_IDLE;
        endcase
      end
    end
  end

  assign if_pc        = pc;
  assign if_inst      = hit ? line_data : ZERO_WORD;
  assign if_stall_req = !hit;
  assign fetch_state  = state;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory model acking 3 cycles after a request, request
// address scoreboard, table of hit-path vectors and hand-written miss sequences.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               rdy;
  logic [STALL_W-1:0] stall_stat;
  logic               ex_is_branch;
  logic [31:0]        ex_branch_pc;
  logic [31:0]        id_pc;
  logic [31:0]        if_pc;
  logic [31:0]        if_inst;
  logic               if_stall_req;
  if_state_t          fetch_state;

  if_fetch_if #(.ADDR_W(32)) mif ();

  if_fetch #(.ICACHE_IDX_W(7), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall_stat   (stall_stat),
    .ex_is_branch (ex_is_branch),
    .ex_branch_pc (ex_branch_pc),
    .id_pc        (id_pc),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_stall_req (if_stall_req),
    .mem          (mif),
    .fetch_state  (fetch_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        prev_ack;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1F3C, a[15:0] ^ 16'hA5A5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main process drives/samples at posedge+2; the memory model updates at posedge+1.
  task automatic step();
    @(posedge clk);
    #2;
    prev_ack = mif.mem_ack;
  endtask

  // memory model + request scoreboard
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;
  initial begin
    mif.mem_ack  = 1'b0;
    mif.mem_data = 32'hDEAD_BEEF;
    m_busy = 1'b0;
    m_cnt  = 0;
    m_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_busy = 1'b0;
        mif.mem_ack  = 1'b0;
        mif.mem_data = 32'hDEAD_BEEF;
      end else begin
        if (m_busy) begin
          if (mif.mem_ack) begin
            if (rdy) m_busy = 1'b0;
            mif.mem_ack  = 1'b0;
            mif.mem_data = 32'hDEAD_BEEF;
          end else begin
            m_cnt++;
            if (m_cnt >= 3) begin
              mif.mem_ack  = 1'b1;
              mif.mem_data = mem_word(m_addr);
            end
          end
        end
        if (!m_busy && mif.mem_req) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_addr = mif.mem_addr;
          if (exp_q.size() == 0) begin
            chk("unexpected_mem_req", m_addr, 32'hFFFF_FFFF);
          end else begin
            chk("mem_addr_sb", m_addr, exp_q.pop_front());
          end
        end
      end
    end
  end

  // Step until the instruction at addr is presented as a hit, checking the
  // stall outputs on the way and that the hit follows an ack by one cycle.
  task automatic wait_hit(input logic [31:0] addr);
    logic done = 1'b0;
    logic ack_before;
    for (int i = 0; i < 40 && !done; i++) begin
      ack_before = mif.mem_ack;
      step();
      if (!if_stall_req) begin
        done = 1'b1;
      end else begin
        chk("inst_zero_on_miss", if_inst, 32'h0);
      end
    end
    if (!done) begin
      chk("wait_hit_timeout", 32'h0, 32'h1);
    end else begin
      chk("hit_after_ack", {31'h0, ack_before}, 32'h1);
      chk("hit_pc", if_pc, addr);
      chk("hit_inst", if_inst, mem_word(addr));
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        stall;
    logic        br;
    logic [31:0] br_pc;
    logic [31:0] idpc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // rdy stall br br_pc id_pc exp_pc ; starting from pc=0 presented as a hit
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h40, 32'h4};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h40, 32'h8};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0,  32'h40, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h40, 32'h4};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h40, 32'h4};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h40, 32'h4};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h40, 32'h8};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h0,  32'h40, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h40, 32'h40, 32'h4};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h40, 32'h4};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h8,  32'h40, 32'h8};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h0,  32'h40, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h4,  32'h4,  32'h4};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h0,  32'h40, 32'h0};

    rst = 1'b1; rdy = 1'b1; stall_stat = '0;
    ex_is_branch = 1'b0; ex_branch_pc = '0; id_pc = 32'h40;
    prev_ack = 1'b0;

    // reset state
    step(); step();
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_mem_req", {31'h0, mif.mem_req}, 32'h0);
    chk("rst_mem_addr", mif.mem_addr, 32'h0);
    chk("rst_stall_req", {31'h0, if_stall_req}, 32'h1);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_state", 32'(fetch_state), 32'(IF_IDLE));

    // first miss: request one cycle after reset release
    exp_q.push_back(32'h0);
    rst = 1'b0;
    step();
    chk("first_mem_req", {31'h0, mif.mem_req}, 32'h1);
    chk("first_mem_addr", mif.mem_addr, 32'h0);
    chk("first_state", 32'(fetch_state), 32'(IF_WAIT));
    wait_hit(32'h0);
    exp_q.push_back(32'h4);
    wait_hit(32'h4);
    exp_q.push_back(32'h8);
    wait_hit(32'h8);

    // redirect to the preloaded lines
    ex_is_branch = 1'b1; ex_branch_pc = 32'h0; id_pc = 32'h40;
    step();
    ex_is_branch = 1'b0;
    chk("redir_pc", if_pc, 32'h0);
    chk("redir_hit", {31'h0, if_stall_req}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      rdy = vecs[i].rdy;
      stall_stat = {5'b0, vecs[i].stall};
      ex_is_branch = vecs[i].br;
      ex_branch_pc = vecs[i].br_pc;
      id_pc = vecs[i].idpc;
      step();
      chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_inst", i), if_inst, mem_word(vecs[i].exp_pc));
      chk($sformatf("vec%0d_stall_req", i), {31'h0, if_stall_req}, 32'h0);
      chk($sformatf("vec%0d_mem_req", i), {31'h0, mif.mem_req}, 32'h0);
    end
    rdy = 1'b1; stall_stat = '0; ex_is_branch = 1'b0; id_pc = 32'h40;

    // redirect during WAIT: the fill still targets the original address
    ex_is_branch = 1'b1; ex_branch_pc = 32'h20;
    step();
    ex_is_branch = 1'b0;
    chk("w_pc20", if_pc, 32'h20);
    chk("w_miss20", {31'h0, if_stall_req}, 32'h1);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h100);
    step();
    chk("w_req", {31'h0, mif.mem_req}, 32'h1);
    chk("w_addr", mif.mem_addr, 32'h20);
    chk("w_state", 32'(fetch_state), 32'(IF_WAIT));
    ex_is_branch = 1'b1; ex_branch_pc = 32'h100;
    step();
    ex_is_branch = 1'b0;
    chk("w_redir_pc", if_pc, 32'h100);
    chk("w_addr_stable", mif.mem_addr, 32'h20);
    chk("w_req_stable", {31'h0, mif.mem_req}, 32'h1);
    wait_hit(32'h100);
    ex_is_branch = 1'b1; ex_branch_pc = 32'h20;
    step();
    ex_is_branch = 1'b0;
    chk("w_line20_pc", if_pc, 32'h20);
    chk("w_line20_hit", {31'h0, if_stall_req}, 32'h0);
    chk("w_line20_inst", if_inst, mem_word(32'h20));

    // rdy low mid-WAIT while the model asserts an ack
    exp_q.push_back(32'h24);
    step();
    chk("r_pc24", if_pc, 32'h24);
    step();
    chk("r_req", {31'h0, mif.mem_req}, 32'h1);
    step(); step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("r_hold%0d_pc", i), if_pc, 32'h24);
      chk($sformatf("r_hold%0d_state", i), 32'(fetch_state), 32'(IF_WAIT));
      chk($sformatf("r_hold%0d_req", i), {31'h0, mif.mem_req}, 32'h1);
      chk($sformatf("r_hold%0d_addr", i), mif.mem_addr, 32'h24);
      chk($sformatf("r_hold%0d_stall", i), {31'h0, if_stall_req}, 32'h1);
    end
    rdy = 1'b1;
    stall_stat = 6'b000001;
    wait_hit(32'h24);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("end_hold%0d_pc", i), if_pc, 32'h24);
      chk($sformatf("end_hold%0d_inst", i), if_inst, mem_word(32'h24));
    end

    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("mem_idle", {31'h0, mif.mem_req}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
